// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared widths, command codes, flag bundle and operand-need
//                helper for the alu_core datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH     = 8;
    localparam int CMD_WIDTH = 4;

    // Arithmetic command set (mode = 1)
    typedef enum logic [CMD_WIDTH-1:0] {
        CMD_ADD     = 4'd0,
        CMD_SUB     = 4'd1,
        CMD_ADD_CIN = 4'd2,
        CMD_SUB_CIN = 4'd3,
        CMD_INC_A   = 4'd4,
        CMD_DEC_A   = 4'd5,
        CMD_INC_B   = 4'd6,
        CMD_DEC_B   = 4'd7,
        CMD_CMP     = 4'd8,
        CMD_ADD_MUL = 4'd9,
        CMD_SH_MUL  = 4'd10,
        CMD_SADD    = 4'd11,
        CMD_SSUB    = 4'd12
    } arith_cmd_e;

    // Logical command set (mode = 0)
    typedef enum logic [CMD_WIDTH-1:0] {
        CMD_AND     = 4'd0,
        CMD_NAND    = 4'd1,
        CMD_OR      = 4'd2,
        CMD_NOR     = 4'd3,
        CMD_XOR     = 4'd4,
        CMD_XNOR    = 4'd5,
        CMD_NOT_A   = 4'd6,
        CMD_NOT_B   = 4'd7,
        CMD_SHR1_A  = 4'd8,
        CMD_SHL1_A  = 4'd9,
        CMD_SHR1_B  = 4'd10,
        CMD_SHL1_B  = 4'd11,
        CMD_ROL_A_B = 4'd12,
        CMD_ROR_A_B = 4'd13
    } logic_cmd_e;

    // Status flags travel together through the output register
    typedef struct packed {
        logic oflow;
        logic cout;
        logic g;
        logic l;
        logic e;
        logic err;
        logic neg;
        logic zero;
    } alu_flags_t;

    // Operands a command consumes: bit0 = A, bit1 = B. Undefined codes
    // return 00; they are flagged as illegal by the decoder itself.
    function automatic logic [1:0] operand_need(input logic mode,
                                                input logic [CMD_WIDTH-1:0] cmd);
        logic [1:0] need;
        need = 2'b00;
        if (mode) begin
            case (cmd)
                CMD_INC_A, CMD_DEC_A: need = 2'b01;
                CMD_INC_B, CMD_DEC_B: need = 2'b10;
                CMD_ADD, CMD_SUB, CMD_ADD_CIN, CMD_SUB_CIN, CMD_CMP,
                CMD_ADD_MUL, CMD_SH_MUL, CMD_SADD, CMD_SSUB: need = 2'b11;
                default: need = 2'b00;
            endcase
        end else begin
            case (cmd)
                CMD_NOT_A, CMD_SHR1_A, CMD_SHL1_A: need = 2'b01;
                CMD_NOT_B, CMD_SHR1_B, CMD_SHL1_B: need = 2'b10;
                CMD_AND, CMD_NAND, CMD_OR, CMD_NOR, CMD_XOR, CMD_XNOR,
                CMD_ROL_A_B, CMD_ROR_A_B: need = 2'b11;
                default: need = 2'b00;
            endcase
        end
        return need;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_if
//  Description : Operand/command bus into alu_core and result/flag bus out.
//                master = requester, slave = alu_core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_if #(
    parameter int WIDTH     = alu_pkg::WIDTH,
    parameter int CMD_WIDTH = alu_pkg::CMD_WIDTH
);
    logic                   ce;
    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic                   cin;
    logic                   mode;
    logic [1:0]             inp_valid;
    logic [CMD_WIDTH-1:0]   cmd;

    logic [2*WIDTH-1:0]     res;
    logic                   oflow;
    logic                   cout;
    logic                   g;
    logic                   l;
    logic                   e;
    logic                   err;
    logic                   neg;
    logic                   zero;

    modport master (
        output ce, opa, opb, cin, mode, inp_valid, cmd,
        input  res, oflow, cout, g, l, e, err, neg, zero
    );

    modport slave (
        input  ce, opa, opb, cin, mode, inp_valid, cmd,
        output res, oflow, cout, g, l, e, err, neg, zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_stage
//  Description : Product logic for ADD_MUL / SH_MUL plus the extra pipeline
//                register that gives the multiply commands their third cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_stage #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_ce,
    input  wire logic               i_start,    // stage 2 holds a multiply
    input  wire logic               i_add_mul,  // 1 = ADD_MUL, 0 = SH_MUL
    input  wire logic               i_err,      // multiply lacks an operand
    input  wire logic [WIDTH-1:0]   i_opa,
    input  wire logic [WIDTH-1:0]   i_opb,
    output logic                    o_valid,
    output logic [2*WIDTH-1:0]      o_prod,
    output logic                    o_err
);
    localparam logic [2*WIDTH-1:0] c_one = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] w_a_inc;
    logic [2*WIDTH-1:0] w_b_inc;
    logic [2*WIDTH-1:0] w_a_sh;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;

    logic               r_valid;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_err;

    // Operands are widened first so (A+1)*(B+1) keeps all 2*WIDTH bits
    assign w_a_inc = {{WIDTH{1'b0}}, i_opa} + c_one;
    assign w_b_inc = {{WIDTH{1'b0}}, i_opb} + c_one;
    // A<<1 is truncated to WIDTH before the multiply
    assign w_a_sh  = {{WIDTH{1'b0}}, i_opa[WIDTH-2:0], 1'b0};
    assign w_b_ext = {{WIDTH{1'b0}}, i_opb};
    assign w_prod  = i_add_mul ? (w_a_inc * w_b_inc) : (w_a_sh * w_b_ext);

    // Extra multiply register; a missing operand forces a zero product
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_prod  <= '0;
            r_err   <= 1'b0;
        end else if (i_ce) begin
            r_valid <= i_start;
            r_prod  <= (i_start && !i_err) ? w_prod : '0;
            r_err   <= i_start && i_err;
        end
    end

    assign o_valid = r_valid;
    assign o_prod  = r_prod;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Two-stage registered integer ALU (three stages for the
//                multiply commands) with carry/overflow/compare/sign flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core #(
    parameter int WIDTH     = alu_pkg::WIDTH,
    parameter int CMD_WIDTH = alu_pkg::CMD_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_if.slave        bus
);
    import alu_pkg::*;

    localparam logic [WIDTH:0] c_one = {{WIDTH{1'b0}}, 1'b1};

    // Stage 1: captured command and operands
    logic                   r_mode;
    logic                   r_cin;
    logic [WIDTH-1:0]       r_opa;
    logic [WIDTH-1:0]       r_opb;
    logic [CMD_WIDTH-1:0]   r_cmd;
    logic [1:0]             r_inp_valid;

    // Stage 2: registered result and flags
    logic [2*WIDTH-1:0]     r_res;
    alu_flags_t             r_flags;

    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_sum_c;
    logic [WIDTH:0]         w_diff;
    logic [WIDTH:0]         w_diff_c;
    logic [WIDTH:0]         w_inc_a;
    logic [WIDTH:0]         w_dec_a;
    logic [WIDTH:0]         w_inc_b;
    logic [WIDTH:0]         w_dec_b;
    logic [WIDTH-1:0]       w_rol;
    logic [WIDTH-1:0]       w_ror;
    logic [$clog2(WIDTH)-1:0] w_amt;
    logic [1:0]             w_need;
    logic                   w_missing;
    logic                   w_is_mul;
    logic                   w_is_add_mul;
    logic [2*WIDTH-1:0]     w_res;
    alu_flags_t             w_flags;
    logic                   w_mul_valid;
    logic [2*WIDTH-1:0]     w_mul_prod;
    logic                   w_mul_err;
    alu_flags_t             w_mul_flags;

    function automatic logic [2*WIDTH-1:0] zext_w(input logic [WIDTH-1:0] x);
        return {{WIDTH{1'b0}}, x};
    endfunction

    function automatic logic [2*WIDTH-1:0] zext_w1(input logic [WIDTH:0] x);
        return {{(WIDTH-1){1'b0}}, x};
    endfunction

    // Stage 1 capture; reset wins over ce
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= 1'b0;
            r_cin       <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_cmd       <= '0;
            r_inp_valid <= 2'b00;
        end else if (bus.ce) begin
            r_mode      <= bus.mode;
            r_cin       <= bus.cin;
            r_opa       <= bus.opa;
            r_opb       <= bus.opb;
            r_cmd       <= bus.cmd;
            r_inp_valid <= bus.inp_valid;
        end
    end

    // Shared WIDTH+1 adders: bit WIDTH is the carry, or the borrow for
    // subtraction (the difference is negative exactly when A < B (+cin)).
    assign w_sum    = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_sum_c  = w_sum + {{WIDTH{1'b0}}, r_cin};
    assign w_diff   = {1'b0, r_opa} - {1'b0, r_opb};
    assign w_diff_c = w_diff - {{WIDTH{1'b0}}, r_cin};
    assign w_inc_a  = {1'b0, r_opa} + c_one;
    assign w_dec_a  = {1'b0, r_opa} - c_one;
    assign w_inc_b  = {1'b0, r_opb} + c_one;
    assign w_dec_b  = {1'b0, r_opb} - c_one;

    // Rotates use only the low log2(WIDTH) bits of B as the amount
    assign w_amt = r_opb[$clog2(WIDTH)-1:0];
    assign w_rol = (r_opa << w_amt) | (r_opa >> (WIDTH - int'(w_amt)));
    assign w_ror = (r_opa >> w_amt) | (r_opa << (WIDTH - int'(w_amt)));

    assign w_need       = operand_need(r_mode, r_cmd);
    assign w_missing    = (r_inp_valid == 2'b00) || ((w_need & ~r_inp_valid) != 2'b00);
    assign w_is_add_mul = (r_cmd == CMD_ADD_MUL);
    assign w_is_mul     = r_mode && (w_is_add_mul || (r_cmd == CMD_SH_MUL));

    // Stage 2 decode for every non-multiply command
    always_comb begin
        w_res   = '0;
        w_flags = '0;
        if (w_missing) begin
            w_flags.err = 1'b1;
        end else if (r_mode) begin
            case (r_cmd)
                CMD_ADD: begin
                    w_res        = zext_w(w_sum[WIDTH-1:0]);
                    w_flags.cout = w_sum[WIDTH];
                end
                CMD_SUB: begin
                    w_res         = zext_w(w_diff[WIDTH-1:0]);
                    w_flags.oflow = w_diff[WIDTH];
                end
                CMD_ADD_CIN: begin
                    w_res        = zext_w(w_sum_c[WIDTH-1:0]);
                    w_flags.cout = w_sum_c[WIDTH];
                end
                CMD_SUB_CIN: begin
                    w_res         = zext_w(w_diff_c[WIDTH-1:0]);
                    w_flags.oflow = w_diff_c[WIDTH];
                end
                CMD_INC_A: w_res = zext_w1(w_inc_a);
                CMD_DEC_A: w_res = zext_w1(w_dec_a);
                CMD_INC_B: w_res = zext_w1(w_inc_b);
                CMD_DEC_B: w_res = zext_w1(w_dec_b);
                CMD_CMP: begin
                    w_flags.g = (r_opa > r_opb);
                    w_flags.l = (r_opa < r_opb);
                    w_flags.e = (r_opa == r_opb);
                end
                // Multiplies are produced by the mul stage, not here
                CMD_ADD_MUL, CMD_SH_MUL: w_res = '0;
                CMD_SADD: begin
                    w_res         = zext_w(w_sum[WIDTH-1:0]);
                    w_flags.oflow = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                                    (w_sum[WIDTH-1] != r_opa[WIDTH-1]);
                    w_flags.neg   = w_sum[WIDTH-1];
                    w_flags.zero  = (w_sum[WIDTH-1:0] == '0);
                end
                CMD_SSUB: begin
                    w_res         = zext_w(w_diff[WIDTH-1:0]);
                    w_flags.oflow = (r_opa[WIDTH-1] != r_opb[WIDTH-1]) &&
                                    (w_diff[WIDTH-1] != r_opa[WIDTH-1]);
                    w_flags.neg   = w_diff[WIDTH-1];
                    w_flags.zero  = (w_diff[WIDTH-1:0] == '0);
                end
                default: w_flags.err = 1'b1;
            endcase
        end else begin
            case (r_cmd)
                CMD_AND:    w_res = zext_w(r_opa & r_opb);
                CMD_NAND:   w_res = zext_w(~(r_opa & r_opb));
                CMD_OR:     w_res = zext_w(r_opa | r_opb);
                CMD_NOR:    w_res = zext_w(~(r_opa | r_opb));
                CMD_XOR:    w_res = zext_w(r_opa ^ r_opb);
                CMD_XNOR:   w_res = zext_w(~(r_opa ^ r_opb));
                CMD_NOT_A:  w_res = zext_w(~r_opa);
                CMD_NOT_B:  w_res = zext_w(~r_opb);
                CMD_SHR1_A: w_res = zext_w(r_opa >> 1);
                CMD_SHL1_A: w_res = zext_w(r_opa << 1);
                CMD_SHR1_B: w_res = zext_w(r_opb >> 1);
                CMD_SHL1_B: w_res = zext_w(r_opb << 1);
                // Out-of-range rotate amount is flagged but the rotate is kept
                CMD_ROL_A_B: begin
                    w_res       = zext_w(w_rol);
                    w_flags.err = |r_opb[WIDTH-1:4];
                end
                CMD_ROR_A_B: begin
                    w_res       = zext_w(w_ror);
                    w_flags.err = |r_opb[WIDTH-1:4];
                end
                default: w_flags.err = 1'b1;
            endcase
        end
    end

    alu_mul_stage #(
        .WIDTH      (WIDTH)
    ) u_mul (
        .clk        (clk),
        .rst        (rst),
        .i_ce       (bus.ce),
        .i_start    (w_is_mul),
        .i_add_mul  (w_is_add_mul),
        .i_err      (w_missing),
        .i_opa      (r_opa),
        .i_opb      (r_opb),
        .o_valid    (w_mul_valid),
        .o_prod     (w_mul_prod),
        .o_err      (w_mul_err)
    );

    // A finished multiply reports only its error flag
    always_comb begin
        w_mul_flags     = '0;
        w_mul_flags.err = w_mul_err;
    end

    // Output register. A non-multiply in stage 2 always lands; otherwise a
    // multiply leaving the extra stage lands; otherwise outputs hold. A
    // non-multiply issued right behind a multiply therefore displaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res   <= '0;
            r_flags <= '0;
        end else if (bus.ce) begin
            if (!w_is_mul) begin
                r_res   <= w_res;
                r_flags <= w_flags;
            end else if (w_mul_valid) begin
                r_res   <= w_mul_prod;
                r_flags <= w_mul_flags;
            end
        end
    end

    assign bus.res   = r_res;
    assign bus.oflow = r_flags.oflow;
    assign bus.cout  = r_flags.cout;
    assign bus.g     = r_flags.g;
    assign bus.l     = r_flags.l;
    assign bus.e     = r_flags.e;
    assign bus.err   = r_flags.err;
    assign bus.neg   = r_flags.neg;
    assign bus.zero  = r_flags.zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_core
//  Description : Self-checking bench for alu_core: directed vector table,
//                hold/reset/multiply sequences and randomized commands
//                checked against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_core;

    localparam logic [7:0] F_OFLOW = 8'h80;
    localparam logic [7:0] F_COUT  = 8'h40;
    localparam logic [7:0] F_G     = 8'h20;
    localparam logic [7:0] F_L     = 8'h10;
    localparam logic [7:0] F_E     = 8'h08;
    localparam logic [7:0] F_ERR   = 8'h04;
    localparam logic [7:0] F_NEG   = 8'h02;
    localparam logic [7:0] F_ZERO  = 8'h01;

    typedef struct {
        logic        mode;
        logic [3:0]  cmd;
        logic [1:0]  iv;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [15:0] res;
        logic [7:0]  fl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[23];

    always #5 clk = ~clk;

    alu_if #(.WIDTH(8), .CMD_WIDTH(4)) bus ();

    alu_core #(.WIDTH(8), .CMD_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] dut_flags();
        return {bus.oflow, bus.cout, bus.g, bus.l, bus.e, bus.err, bus.neg, bus.zero};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.mode      = mode;
        bus.cmd       = cmd;
        bus.inp_valid = iv;
        bus.opa       = a;
        bus.opb       = b;
        bus.cin       = cin;
    endtask

    // Reference model computed directly from the command definitions
    function automatic void model(input logic mode, input int cmd, input logic [1:0] iv,
                                  input int a, input int b, input int cin,
                                  output logic [15:0] res, output logic [7:0] fl);
        int r, sa, sb, n;
        bit need_a, need_b, bad;
        r = 0; fl = 8'h00; bad = 0; need_a = 1; need_b = 1; res = 16'h0;
        if (mode) begin
            if (cmd >= 13) bad = 1;
            else if (cmd == 4 || cmd == 5) need_b = 0;
            else if (cmd == 6 || cmd == 7) need_a = 0;
        end else begin
            if (cmd >= 14) bad = 1;
            else if (cmd == 6 || cmd == 8 || cmd == 9) need_b = 0;
            else if (cmd == 7 || cmd == 10 || cmd == 11) need_a = 0;
        end
        if (bad || iv == 2'b00 || (need_a && !iv[0]) || (need_b && !iv[1])) begin
            fl = F_ERR;
            return;
        end
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        n  = b % 8;
        if (mode) begin
            case (cmd)
                0:  begin r = a + b;       if (r > 255) fl |= F_COUT;      r = r % 256; end
                1:  begin r = a - b;       if (a < b) fl |= F_OFLOW;       r = (r + 512) % 256; end
                2:  begin r = a + b + cin; if (r > 255) fl |= F_COUT;      r = r % 256; end
                3:  begin r = a - b - cin; if (a < b + cin) fl |= F_OFLOW; r = (r + 512) % 256; end
                4:  r = (a + 1) % 512;
                5:  r = (a - 1 + 512) % 512;
                6:  r = (b + 1) % 512;
                7:  r = (b - 1 + 512) % 512;
                8:  begin
                        r = 0;
                        if (a > b) fl |= F_G;
                        else if (a < b) fl |= F_L;
                        else fl |= F_E;
                    end
                9:  r = ((a + 1) * (b + 1)) % 65536;
                10: r = ((2 * a) % 256) * b;
                default: begin
                        r = (cmd == 11) ? sa + sb : sa - sb;
                        if (r > 127 || r < -128) fl |= F_OFLOW;
                        r = (r + 512) % 256;
                        if (r >= 128) fl |= F_NEG;
                        if (r == 0) fl |= F_ZERO;
                    end
            endcase
        end else begin
            case (cmd)
                0:  r = a & b;
                1:  r = 255 - (a & b);
                2:  r = a | b;
                3:  r = 255 - (a | b);
                4:  r = a ^ b;
                5:  r = 255 - (a ^ b);
                6:  r = 255 - a;
                7:  r = 255 - b;
                8:  r = a / 2;
                9:  r = (a * 2) % 256;
                10: r = b / 2;
                11: r = (b * 2) % 256;
                12: begin r = ((a << n) | (a >> (8 - n))) % 256; if (b >= 16) fl |= F_ERR; end
                default: begin r = ((a >> n) | (a << (8 - n))) % 256; if (b >= 16) fl |= F_ERR; end
            endcase
        end
        res = r[15:0];
    endfunction

    // Present one command, wait its latency, compare result and flags
    task automatic run_vec(input string name, input logic mode, input logic [3:0] cmd,
                           input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [15:0] eres, input logic [7:0] efl);
        int lat;
        lat = (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 3 : 2;
        @(negedge clk);
        drive(mode, cmd, iv, a, b, cin);
        repeat (lat) @(posedge clk);
        #1;
        check({name, " res"}, bus.res, eres);
        check({name, " flags"}, {8'h00, dut_flags()}, {8'h00, efl});
    endtask

    initial begin
        logic [15:0] mres;
        logic [7:0]  mfl;
        logic        rm;
        logic [3:0]  rc;
        logic [1:0]  riv;
        logic [7:0]  ra, rb;
        logic        rcin;

        vecs[0]  = '{1'b1, 4'd0,  2'b11, 8'hFF, 8'h01, 1'b0, 16'h0000, F_COUT};
        vecs[1]  = '{1'b1, 4'd8,  2'b11, 8'h10, 8'h20, 1'b0, 16'h0000, F_L};
        vecs[2]  = '{1'b1, 4'd8,  2'b11, 8'h33, 8'h33, 1'b0, 16'h0000, F_E};
        vecs[3]  = '{1'b1, 4'd9,  2'b11, 8'h02, 8'h03, 1'b0, 16'h000C, 8'h00};
        vecs[4]  = '{1'b1, 4'd10, 2'b11, 8'h81, 8'h02, 1'b0, 16'h0004, 8'h00};
        vecs[5]  = '{1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0, 16'h0003, 8'h00};
        vecs[6]  = '{1'b0, 4'd12, 2'b11, 8'h81, 8'h11, 1'b0, 16'h0003, F_ERR};
        vecs[7]  = '{1'b1, 4'd1,  2'b01, 8'h50, 8'h10, 1'b0, 16'h0000, F_ERR};
        vecs[8]  = '{1'b1, 4'd0,  2'b00, 8'h12, 8'h34, 1'b0, 16'h0000, F_ERR};
        vecs[9]  = '{1'b0, 4'd15, 2'b11, 8'h12, 8'h34, 1'b0, 16'h0000, F_ERR};
        vecs[10] = '{1'b1, 4'd4,  2'b01, 8'hFF, 8'h00, 1'b0, 16'h0100, 8'h00};
        vecs[11] = '{1'b1, 4'd5,  2'b01, 8'h00, 8'h00, 1'b0, 16'h01FF, 8'h00};
        vecs[12] = '{1'b1, 4'd11, 2'b11, 8'h7F, 8'h01, 1'b0, 16'h0080, F_OFLOW | F_NEG};
        vecs[13] = '{1'b1, 4'd12, 2'b11, 8'h80, 8'h80, 1'b0, 16'h0000, F_ZERO};
        vecs[14] = '{1'b1, 4'd3,  2'b11, 8'h05, 8'h05, 1'b1, 16'h00FF, F_OFLOW};
        vecs[15] = '{1'b0, 4'd13, 2'b11, 8'h01, 8'h03, 1'b0, 16'h0020, 8'h00};
        vecs[16] = '{1'b1, 4'd9,  2'b11, 8'hFF, 8'hFF, 1'b0, 16'h0000, 8'h00};
        vecs[17] = '{1'b0, 4'd1,  2'b11, 8'hF0, 8'h0F, 1'b0, 16'h00FF, 8'h00};
        vecs[18] = '{1'b1, 4'd6,  2'b10, 8'h00, 8'h07, 1'b0, 16'h0008, 8'h00};
        vecs[19] = '{1'b1, 4'd13, 2'b11, 8'h12, 8'h34, 1'b0, 16'h0000, F_ERR};
        vecs[20] = '{1'b1, 4'd10, 2'b01, 8'h05, 8'h05, 1'b0, 16'h0000, F_ERR};
        vecs[21] = '{1'b1, 4'd1,  2'b11, 8'h10, 8'h20, 1'b0, 16'h00F0, F_OFLOW};
        vecs[22] = '{1'b1, 4'd2,  2'b11, 8'hFF, 8'h00, 1'b1, 16'h0000, F_COUT};

        rst    = 1'b1;
        bus.ce = 1'b1;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset res", bus.res, 16'h0000);
        check("reset flags", {8'h00, dut_flags()}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 23; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].mode, vecs[i].cmd, vecs[i].iv,
                    vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].fl);
        end

        // ce=0 freezes outputs while inputs change
        run_vec("hold_pre", 1'b1, 4'd0, 2'b11, 8'h12, 8'h34, 1'b0, 16'h0046, 8'h00);
        @(negedge clk);
        bus.ce = 1'b0;
        drive(1'b1, 4'd1, 2'b11, 8'hAA, 8'h55, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("hold res", bus.res, 16'h0046);
        check("hold flags", {8'h00, dut_flags()}, 16'h0000);
        @(negedge clk);
        bus.ce = 1'b1;

        // ce=0 also freezes the extra multiply stage
        run_vec("mulfrz_pre", 1'b1, 4'd0, 2'b11, 8'h12, 8'h34, 1'b0, 16'h0046, 8'h00);
        @(negedge clk);
        drive(1'b1, 4'd9, 2'b11, 8'h02, 8'h03, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mul not yet out", bus.res, 16'h0046);
        @(negedge clk);
        bus.ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mul frozen", bus.res, 16'h0046);
        @(negedge clk);
        bus.ce = 1'b1;
        @(posedge clk);
        #1;
        check("mul resumes", bus.res, 16'h000C);

        // Reset mid-multiply clears outputs and the captured command
        @(negedge clk);
        drive(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst res", bus.res, 16'h0000);
        check("midrst flags", {8'h00, dut_flags()}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst res", bus.res, 16'h0000);
        check("post-rst flags", {8'h00, dut_flags()}, {8'h00, F_ERR});

        // Randomized commands against the reference model
        for (int i = 0; i < 300; i++) begin
            rm   = 1'($urandom_range(0, 1));
            rc   = 4'($urandom_range(0, 15));
            riv  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            ra   = 8'($urandom);
            rb   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            rcin = 1'($urandom_range(0, 1));
            model(rm, int'(rc), riv, int'(ra), int'(rb), int'(rcin), mres, mfl);
            run_vec($sformatf("rnd%0d m%0d c%0d iv%0d a%0h b%0h ci%0d", i, rm, rc, riv, ra, rb, rcin),
                    rm, rc, riv, ra, rb, rcin, mres, mfl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered, parameterised integer ALU with a 2-stage pipeline. Inputs are captured on one clock edge and the result is registered on the next.
- `mode` selects the command set: 1 = arithmetic, 0 = logical.
- Produces a double-width result plus carry, overflow, compare, error, negative and zero flags.
- Standalone datapath block; the shared `defines` supply widths and command codes.

Parameters:
- WIDTH, 8, operand width.
- CMD_WIDTH, 4, command field width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  clock enable; 0 freezes both pipeline stages.
- opa  in  WIDTH  operand A.
- opb  in  WIDTH  operand B.
- cin  in  1  carry in.
- mode  in  1  1 = arithmetic, 0 = logical.
- inp_valid  in  2  bit0 = opa valid, bit1 = opb valid.
- cmd  in  CMD_WIDTH  command.
- res  out  2*WIDTH  result, zero-extended.
- oflow  out  1  overflow/borrow.
- cout  out  1  carry out.
- g  out  1  A>B.
- l  out  1  A<B.
- e  out  1  A==B.
- err  out  1  illegal operation.
- neg  out  1  signed result negative.
- zero  out  1  signed result zero.

Behaviour:
- Reset: rst high at a rising edge clears every input register and every output to 0. Reset has priority over ce. Reset mid-operation discards the in-flight result.
- Pipeline:
  - Stage 1 registers opa, opb, cin, mode, cmd, inp_valid when ce=1.
  - Stage 2 computes and registers all outputs when ce=1.
  - Latency is 2 clocks for all commands except the two multiply commands, which take 3 clocks (one extra register stage). Outputs are stable until the next update.
  - ce=0 holds all state.
- Flag defaults: every flag not named for the active command is 0.
- Operand requirement: a command needing an operand whose inp_valid bit is 0 gives err=1 and res=0. inp_valid=00 always gives err=1.
- Arithmetic commands (mode=1); unsigned unless stated:
  - 0 ADD: res=A+B, cout=bit WIDTH.
  - 1 SUB: res=A-B, oflow=(A<B).
  - 2 ADD_CIN: res=A+B+cin, cout set.
  - 3 SUB_CIN: res=A-B-cin, oflow=(A<B+cin).
  - 4 INC_A, 5 DEC_A: need A only.
  - 6 INC_B, 7 DEC_B: need B only.
  - Increment/decrement results are WIDTH+1 bits, so 0xFF+1=0x100 and 0-1=0x1FF.
  - 8 CMP: res=0; exactly one of g/l/e=1.
  - 9 ADD_MUL: res=(A+1)*(B+1), truncated to 2*WIDTH.
  - 10 SH_MUL: res=(A<<1)*B, with A<<1 truncated to WIDTH.
  - 11 SADD: signed A+B; oflow on signed overflow; neg=res[WIDTH-1]; zero=(res[WIDTH-1:0]==0).
  - 12 SSUB: signed A-B; oflow, neg and zero as for SADD.
  - 13..15: err=1.
- Logical commands (mode=0); res upper bits are 0:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR: need both operands.
  - 6 NOT_A, 8 SHR1_A, 9 SHL1_A: need A only.
  - 7 NOT_B, 10 SHR1_B, 11 SHL1_B: need B only.
  - 12 ROL_A_B: A rotated left by B[2:0].
  - 13 ROR_A_B: A rotated right by B[2:0].
  - For 12 and 13, err=1 if B[WIDTH-1:4]!=0; res still holds the rotate.
  - 14..15: err=1.
- When err=1 from an invalid cmd or missing operand, res=0 and all other flags are 0.

Decomposition:
- Package `alu_pkg` holds WIDTH, CMD_WIDTH, arithmetic command codes (ADD..SSUB, including ADD_MUL=9 and SH_MUL=10) and logical command codes.
- One natural sub-module, `alu_mul_stage`, holds the extra multiply pipeline register and the product logic.
- Everything else is combinational logic inside alu_core.

Test Plan:
- mode=1, cmd=0, inp_valid=11, A=0xFF, B=0x01 -> after 2 clocks res=0x0000, cout=1, err=0.
- mode=1, cmd=8, A=0x10, B=0x20 -> l=1, g=0, e=0, res=0. Repeat with A=B=0x33 -> e=1.
- mode=1, cmd=9, A=0x02, B=0x03 -> after 3 clocks res=0x000C. Also cmd=10, A=0x81, B=0x02 -> res=0x0004.
- mode=0, cmd=12, A=0x81, B=0x01 -> res=0x03, err=0. Same with B=0x11 -> err=1.
- mode=1, cmd=1, inp_valid=01 -> err=1, res=0. Also inp_valid=00 on any command -> err=1. mode=0, cmd=15 -> err=1.
- Hold and reset: drive an ADD, then ce=0 for 3 cycles while changing inputs -> outputs unchanged. rst=1 for one edge -> all outputs 0 on the next cycle.
